// File: rtl/bert_pkg.sv
// Shared definitions for the BER tester pattern generator and checker.
// Holds LFSR taps, mode/state encodings and small helpers used on both sides of the link.
package bert_pkg;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned LFSR_W    = 15;
    localparam int unsigned PRBS7_W   = 7;
    localparam int unsigned PERIOD_W  = 16;
    localparam int unsigned INJ_CNT_W = 16;
    localparam int unsigned POP_W     = 4;

    // Feedback taps as bit masks over the 15-bit shift register.
    localparam logic [LFSR_W-1:0]  PRBS7_TAPS  = 15'h0060;
    localparam logic [LFSR_W-1:0]  PRBS15_TAPS = 15'h6000;
    localparam logic [PRBS7_W-1:0] PRBS7_ONES  = 7'h7F;
    localparam logic [LFSR_W-1:0]  PRBS15_ONES = 15'h7FFF;

    typedef enum logic {
        MODE_PRBS7  = 1'b0,
        MODE_PRBS15 = 1'b1
    } prbs_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } tx_state_e;

    // Word as it is staged into the output register.
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              injected;
        logic [POP_W-1:0]  pop;
    } tx_word_t;

    function automatic logic [POP_W-1:0] popcount8(input logic [WORD_W-1:0] v);
        logic [POP_W-1:0]  c;
        logic [WORD_W-1:0] t;
        c = '0;
        t = v;
        for (int i = 0; i < int'(WORD_W); i++) begin
            c = c + POP_W'(t[0]);
            t = t >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs_step8.sv
// Combinational eight-step Fibonacci LFSR advance; first generated bit lands in word MSB.
// Also used by the far-end checker as its reference generator.
module prbs_step8
    import bert_pkg::*;
(
    input  prbs_mode_e        mode,
    input  logic [LFSR_W-1:0] state_in,
    output logic [LFSR_W-1:0] state_out,
    output logic [WORD_W-1:0] word
);

    logic [LFSR_W-1:0] taps;
    logic [LFSR_W-1:0] r;
    logic              n;

    assign taps = (mode == MODE_PRBS15) ? PRBS15_TAPS : PRBS7_TAPS;

    // Upper bits are don't-care in PRBS7 mode; the tap mask keeps them out of feedback.
    always_comb begin
        r    = state_in;
        n    = 1'b0;
        word = '0;
        for (int i = 0; i < int'(WORD_W); i++) begin
            n    = ^(r & taps);
            word = {word[WORD_W-2:0], n};
            r    = {r[LFSR_W-2:0], n};
        end
        state_out = r;
    end

endmodule

// File: rtl/prbs_tx_gen.sv
// Transmit-side PRBS word source with ready/valid output and deliberate error injection.
// The LFSR steps once per registered word; injected errors never feed back into the LFSR.
module prbs_tx_gen
    import bert_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 seed_load,
    input  logic [LFSR_W-1:0]    seed,
    input  logic                 inj_single,
    input  logic [WIDTH-1:0]     inj_mask,
    input  logic [PERIOD_W-1:0]  inj_period,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_W-1:0]     word_count,
    output logic [INJ_CNT_W-1:0] inj_count,
    output logic                 busy
);

    localparam int unsigned INJ_SUM_W = INJ_CNT_W + 1;

    tx_state_e             state;
    tx_state_e             state_nxt;
    prbs_mode_e            mode_q;
    logic [LFSR_W-1:0]     lfsr;
    logic [LFSR_W-1:0]     lfsr_step;
    logic [WORD_W-1:0]     prbs_word;
    logic [PERIOD_W-1:0]   pcnt;
    logic                  armed;
    logic                  out_inj;
    logic [POP_W-1:0]      out_pop;

    logic                  accept_c;
    logic                  load_word_c;
    logic                  drop_valid_c;
    logic                  seed_take_c;
    logic                  period_hit_c;
    logic                  inject_c;
    logic [LFSR_W-1:0]     seed_eff_c;
    tx_word_t              tx_nxt_c;
    logic [INJ_SUM_W-1:0]  inj_sum_c;
    logic [WORD_W-1:0]     mask_c;

    prbs_step8 u_step (
        .mode      (mode_q),
        .state_in  (lfsr),
        .state_out (lfsr_step),
        .word      (prbs_word)
    );

    // Next-state and control strobes.
    always_comb begin
        state_nxt    = state;
        load_word_c  = 1'b0;
        drop_valid_c = 1'b0;
        accept_c     = out_valid && out_ready;
        seed_take_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                seed_take_c = seed_load;
                if (en) begin
                    state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                load_word_c = 1'b1;
                state_nxt   = ST_RUN;
            end
            ST_RUN: begin
                if (accept_c) begin
                    if (en) begin
                        load_word_c = 1'b1;
                    end else begin
                        drop_valid_c = 1'b1;
                        state_nxt    = ST_IDLE;
                    end
                end else if (!en) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept_c) begin
                    drop_valid_c = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Seed selection: an all-zero seed in the active width would lock the LFSR.
    always_comb begin
        seed_eff_c = seed;
        if (prbs_mode_e'(mode) == MODE_PRBS15) begin
            if (seed == '0) begin
                seed_eff_c = PRBS15_ONES;
            end
        end else begin
            seed_eff_c = LFSR_W'(seed[PRBS7_W-1:0]);
            if (seed[PRBS7_W-1:0] == '0) begin
                seed_eff_c = LFSR_W'(PRBS7_ONES);
            end
        end
    end

    // Injection decision and staged output word.
    always_comb begin
        mask_c       = WORD_W'(inj_mask);
        period_hit_c = (inj_period != '0) && (pcnt == inj_period - PERIOD_W'(1));
        inject_c     = armed || period_hit_c;
        tx_nxt_c.data     = inject_c ? (prbs_word ^ mask_c) : prbs_word;
        tx_nxt_c.injected = inject_c;
        tx_nxt_c.pop      = popcount8(mask_c);
        inj_sum_c         = {1'b0, inj_count} + INJ_SUM_W'(out_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_PRBS7;
            lfsr       <= PRBS15_ONES;
            pcnt       <= '0;
            armed      <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_inj    <= 1'b0;
            out_pop    <= '0;
            word_count <= '0;
            inj_count  <= '0;
            busy       <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);

            if (seed_take_c) begin
                lfsr       <= seed_eff_c;
                mode_q     <= prbs_mode_e'(mode);
                word_count <= '0;
                pcnt       <= '0;
            end

            if (load_word_c) begin
                lfsr      <= lfsr_step;
                out_valid <= 1'b1;
                out_data  <= WIDTH'(tx_nxt_c.data);
                out_inj   <= tx_nxt_c.injected;
                out_pop   <= tx_nxt_c.pop;
                pcnt      <= period_hit_c ? '0 : pcnt + PERIOD_W'(1);
            end else if (drop_valid_c) begin
                out_valid <= 1'b0;
            end

            if (accept_c) begin
                word_count <= word_count + CNT_W'(1);
                if (out_inj) begin
                    inj_count <= inj_sum_c[INJ_CNT_W] ? '1 : inj_sum_c[INJ_CNT_W-1:0];
                end
            end

            // A pending arm is consumed by the next registered word; re-arming while armed is a no-op.
            if (inj_single && !armed) begin
                armed <= 1'b1;
            end else if (load_word_c && armed) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_tx_gen.sv
// Self-checking bench for prbs_tx_gen: hand-computed seed/first-word table plus
// directed sequences for stall, drain, injection and mid-run reset.
module tb_prbs_tx_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic        seed_load;
    logic [14:0] seed;
    logic        inj_single;
    logic [7:0]  inj_mask;
    logic [15:0] inj_period;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [31:0] word_count;
    logic [15:0] inj_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [14:0] g_r;
    logic        g_mode;

    logic [7:0]  buf7  [254];
    logic [7:0]  buf15 [4095];

    typedef struct {
        logic        mode;
        logic [14:0] seed;
        logic [7:0]  w0;
        logic [7:0]  w1;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    prbs_tx_gen #(.WIDTH(8), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .seed_load  (seed_load),
        .seed       (seed),
        .inj_single (inj_single),
        .inj_mask   (inj_mask),
        .inj_period (inj_period),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count),
        .inj_count  (inj_count),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic gold_load(input logic m, input logic [14:0] s);
        g_mode = m;
        if (m) g_r = (s == 15'h0) ? 15'h7FFF : s;
        else   g_r = (s[6:0] == 7'h0) ? 15'h007F : {8'h00, s[6:0]};
    endtask

    task automatic gold_word(output logic [7:0] w);
        logic n;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n   = g_mode ? (g_r[14] ^ g_r[13]) : (g_r[6] ^ g_r[5]);
            g_r = {g_r[13:0], n};
            w   = {w[6:0], n};
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; seed_load = 1'b0; seed = 15'h0;
        inj_single = 1'b0; inj_mask = 8'h00; inj_period = 16'h0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic m, input logic [14:0] s);
        seed_load = 1'b1; mode = m; seed = s;
        @(negedge clk);
        seed_load = 1'b0;
        gold_load(m, s);
    endtask

    // Accept one word with out_ready high; bounded wait for valid.
    task automatic recv(output logic [7:0] d);
        int n = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL recv_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
        end
        d = out_data;
        @(negedge clk);
    endtask

    task automatic recv_gold(input logic [7:0] x, output logic [7:0] d, output int bad);
        logic [7:0] g;
        recv(d);
        gold_word(g);
        bad = (d !== (g ^ x)) ? 1 : 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] held;
        int bad;
        int b;
        int hits;

        vecs[0] = '{1'b0, 15'h7FFF, 8'h02, 8'h0C};
        vecs[1] = '{1'b0, 15'h0000, 8'h02, 8'h0C};
        vecs[2] = '{1'b0, 15'h7F80, 8'h02, 8'h0C};
        vecs[3] = '{1'b0, 15'h0001, 8'h06, 8'h14};
        vecs[4] = '{1'b1, 15'h7FFF, 8'h00, 8'h02};
        vecs[5] = '{1'b1, 15'h0001, 8'h00, 8'h06};

        // Seed/mode table: reset state, 2-cycle latency, first two words, word count.
        foreach (vecs[i]) begin
            do_reset();
            if (i == 0) begin
                chk("rst_valid", 32'(out_valid), 32'h0);
                chk("rst_data", 32'(out_data), 32'h0);
                chk("rst_wcount", word_count, 32'h0);
                chk("rst_icount", 32'(inj_count), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
            end
            load(vecs[i].mode, vecs[i].seed);
            en = 1'b1;
            @(negedge clk);
            chk("lat1_valid", 32'(out_valid), 32'h0);
            chk("lat1_busy", 32'(busy), 32'h1);
            @(negedge clk);
            chk("lat2_valid", 32'(out_valid), 32'h1);
            recv(d);
            chk("vec_w0", 32'(d), 32'(vecs[i].w0));
            recv(d);
            chk("vec_w1", 32'(d), 32'(vecs[i].w1));
            chk("vec_wcount", word_count, 32'd2);
            en = 1'b0;
            out_ready = 1'b0;
        end

        // PRBS7 free run with ignored mid-run seed_load and a 5-cycle stall, then drain.
        do_reset();
        load(1'b0, 15'h7FFF);
        en = 1'b1;
        bad = 0;
        hits = 0;
        for (int k = 0; k < 254; k++) begin
            if (k == 50) begin
                seed_load = 1'b1; seed = 15'h0001; mode = 1'b1;
            end
            if (k == 100) begin
                out_ready = 1'b0;
                held = out_data;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    if (out_valid !== 1'b1 || out_data !== held) hits++;
                end
            end
            recv_gold(8'h00, d, b);
            seed_load = 1'b0;
            buf7[k] = d;
            bad += b;
        end
        chk("prbs7_golden", 32'(bad), 32'h0);
        chk("stall_hold", 32'(hits), 32'h0);
        chk("prbs7_wcount", word_count, 32'd254);
        bad = 0;
        for (int k = 0; k < 127; k++) begin
            if (buf7[k + 127] !== buf7[k]) bad++;
        end
        chk("prbs7_period", 32'(bad), 32'h0);

        out_ready = 1'b0;
        en = 1'b0;
        held = out_data;
        hits = 0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== held) hits++;
        end
        chk("drain_hold", 32'(hits), 32'h0);
        recv_gold(8'h00, d, b);
        chk("drain_word", 32'(b), 32'h0);
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_busy", 32'(busy), 32'h0);
        chk("drain_wcount", word_count, 32'd255);

        // PRBS15 from seed 1: golden match and no repeat of the opening window.
        do_reset();
        load(1'b1, 15'h0001);
        en = 1'b1;
        bad = 0;
        for (int k = 0; k < 4095; k++) begin
            recv_gold(8'h00, d, b);
            buf15[k] = d;
            bad += b;
        end
        chk("prbs15_golden", 32'(bad), 32'h0);
        hits = 0;
        for (int j = 1; j < 4092; j++) begin
            if (buf15[j] == buf15[0] && buf15[j+1] == buf15[1] &&
                buf15[j+2] == buf15[2] && buf15[j+3] == buf15[3]) hits++;
        end
        chk("prbs15_no_repeat", 32'(hits), 32'h0);
        en = 1'b0;
        out_ready = 1'b0;

        // Single injection, armed twice during a stall: exactly one corrupted word.
        do_reset();
        load(1'b0, 15'h7FFF);
        inj_mask = 8'h81;
        en = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            recv_gold(8'h00, d, b);
            bad += b;
        end
        out_ready = 1'b0;
        inj_single = 1'b1;
        @(negedge clk);
        inj_single = 1'b0;
        @(negedge clk);
        inj_single = 1'b1;
        @(negedge clk);
        inj_single = 1'b0;
        recv_gold(8'h00, d, b);
        chk("inj_pre_word", 32'(b), 32'h0);
        recv_gold(8'h81, d, b);
        chk("inj_word", 32'(b), 32'h0);
        for (int k = 0; k < 5; k++) begin
            recv_gold(8'h00, d, b);
            bad += b;
        end
        chk("inj_clean_words", 32'(bad), 32'h0);
        chk("inj_single_count", 32'(inj_count), 32'd2);

        // Reset mid-run: everything cleared on the next cycle.
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data", 32'(out_data), 32'h0);
        chk("mid_rst_wcount", word_count, 32'h0);
        chk("mid_rst_icount", 32'(inj_count), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        en = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        // Periodic every 4th word, with a single arm landing on periodic hit word 8.
        load(1'b0, 15'h7FFF);
        inj_period = 16'd4;
        inj_mask = 8'h01;
        en = 1'b1;
        bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 7) begin
                out_ready = 1'b0;
                inj_single = 1'b1;
                @(negedge clk);
                inj_single = 1'b0;
            end
            recv_gold(((k % 4) == 0) ? 8'h01 : 8'h00, d, b);
            bad += b;
        end
        chk("periodic_words", 32'(bad), 32'h0);
        chk("periodic_icount", 32'(inj_count), 32'd10);
        chk("periodic_wcount", word_count, 32'd40);
        en = 1'b0;
        @(negedge clk);
        chk("run_stop_valid", 32'(out_valid), 32'h0);
        chk("run_stop_busy", 32'(busy), 32'h0);
        chk("run_stop_wcount", word_count, 32'd41);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prbs_tx_gen.md
Name: prbs_tx_gen

Overview:
- Transmit-side pattern source for the bit-error-ratio tester: produces the 8-bit PRBS word stream that is sent over the link under test.
- The error checker at the far end compares the received word against its own reference copy of this stream.
- Supports deliberate bit-error injection, single-shot or periodic, so the checker's error/BER path can be validated against a known injected count.
- Output is a registered ready/valid word stream; the LFSR advances only when a word is accepted.

Parameters:
- WIDTH, 8, output word width; bits per accepted word. Only 8 is verified.
- CNT_W, 32, width of word_count.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  level; 1 = generate stream, 0 = stop after the pending word
- mode  input  1  0 = PRBS7 (x^7+x^6+1), 1 = PRBS15 (x^15+x^14+1); sampled on seed_load
- seed_load  input  1  pulse; loads seed and mode (IDLE only)
- seed  input  15  LFSR seed; PRBS7 uses seed[6:0]
- inj_single  input  1  pulse; arms one injection on the next accepted word
- inj_mask  input  8  bits XORed into an injected word
- inj_period  input  16  0 = periodic injection off; N = every Nth accepted word injected
- out_valid  output  1  word available
- out_ready  input  1  consumer accepts when out_valid&&out_ready
- out_data  output  8  transmitted word
- word_count  output  CNT_W  accepted words since reset/seed_load, wraps
- inj_count  output  16  total injected bit errors, saturates at 16'hFFFF
- busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE, out_valid=0, out_data=0, word_count=0, inj_count=0, armed=0, period counter=0, mode_q=0, LFSR=all ones.
- States:
  - IDLE: out_valid=0. seed_load loads LFSR and mode_q and clears word_count and the period counter. en=1 -> PRIME.
  - PRIME: compute the first word and register it; out_valid=1 next cycle -> RUN. Latency from en to out_valid is 2 cycles.
  - RUN: on accept, advance the LFSR and present the next word in the same cycle (back-to-back throughput, 1 word/clk). en=0 at accept -> IDLE with out_valid=0.
  - DRAIN: en=0 while out_valid && !out_ready. Hold the word until accepted, then -> IDLE.
  - Valid never drops without an accept.
- seed_load outside IDLE is ignored. A zero seed (in the active width) is replaced by all ones.
- LFSR is Fibonacci, shift-left:
  - PRBS7: n=r[6]^r[5].
  - PRBS15: n=r[14]^r[13].
  - Each step is r<={r[W-2:0],n}.
  - Eight steps per word; the first generated bit goes to out_data[7].
- Stability: out_data stable while out_valid && !out_ready.
- Injection decision is made when the word is registered:
  - inject = armed || (inj_period!=0 && pcnt==inj_period-1).
  - pcnt counts registered words and wraps to 0 on a hit.
  - Injected word = prbs ^ inj_mask. The LFSR itself is never corrupted, so the error does not propagate.
- inj_count += popcount(inj_mask) when an injected word is accepted; saturating.
- armed clears on use. A single and a periodic hit on the same word apply the mask once and count once.
- inj_single while already armed: no effect (one injection).
- inj_mask=0: the word is marked injected, but inj_count adds 0.
- word_count increments on every accept and wraps silently.
- rst mid-stream: everything returns to reset values next cycle; the pending word is lost.

Decomposition:
- Package bert_pkg holds:
  - PRBS7_TAPS/PRBS15_TAPS constants
  - mode encodings
  - state enum (IDLE, PRIME, RUN, DRAIN)
  - popcount8 function, shared with the checker
- Sub-module prbs_step8: combinational 8-step LFSR advance (mode, state in -> next state, word out). The checker reuses it as its reference generator.

Test Plan:
- rst, seed_load seed=15'h7FFF mode=0, en=1, out_ready=1 -> out_valid high 2 cycles after en; words 8'h02, 8'h0C; word_count=2 after two accepts.
- PRBS7 free-run 127 words -> stream repeats every 127 bytes (sequence period 127 bits); mode=1 PRBS15 seed 1 -> no repeat within 4095 words.
- out_ready low 5 cycles mid-stream -> out_data/out_valid held constant; no word skipped versus the golden model.
- inj_single with inj_mask=8'h81 -> exactly one word differs from golden in bits 7 and 0; following words are correct; inj_count=2.
- inj_period=4, inj_mask=8'h01, 40 words, with inj_single coinciding with one periodic hit -> 10 injected words, inj_count=10.
- en dropped while stalled -> word held until accept, then IDLE; rst mid-run -> all outputs zero next cycle.
